// File: rtl/dfp_ustate_scanner.sv
`default_nettype none
// ============================================================================
// dfp_ustate_scanner : front-panel uState scanner and run/stop/step controller
// Rev 1.0
// ============================================================================
module dfp_ustate_scanner #(
   parameter int SETTLE        = 2,
   parameter int STEP_TIMEOUT  = 255,
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic        clk4,
   input  logic        nreset,
   input  logic [7:0]  fpd,
   output logic        nfpua0,
   output logic        nfpuc0,
   output logic        nfpuc1,
   output logic        nfpuc2,
   input  logic        fpfetch,
   inout  wire         nhalt,
   input  logic        cmd_run,
   input  logic        cmd_stop,
   input  logic        cmd_ustep,
   input  logic        cmd_step,
   output logic [7:0]  ua_low,
   output logic [23:0] ucontrol,
   output logic        snap_valid,
   output logic        halted,
   output logic        step_timeout
);

   localparam int CW = $clog2(SETTLE + 1);

   localparam logic [CW-1:0] c_last_low = CW'(SETTLE - 1);
   localparam logic [CW-1:0] c_gap      = CW'(SETTLE);

   localparam logic [1:0] c_slot_ua0 = 2'd0;
   localparam logic [1:0] c_slot_uc0 = 2'd1;
   localparam logic [1:0] c_slot_uc1 = 2'd2;
   localparam logic [1:0] c_slot_uc2 = 2'd3;

   localparam logic [2:0] c_run        = 3'd0;
   localparam logic [2:0] c_halted     = 3'd1;
   localparam logic [2:0] c_ustep      = 3'd2;
   localparam logic [2:0] c_step_exec  = 3'd3;
   localparam logic [2:0] c_step_fetch = 3'd4;

   localparam logic [7:0] c_tmo_load = 8'(STEP_TIMEOUT);

   // ------------------------------------------------------------------------
   // Scanner
   // ------------------------------------------------------------------------
   logic [1:0]    r_slot;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_cur_slot;
   logic [CW-1:0] r_cur_cnt;
   logic          r_cur_on;
   logic [7:0]    r_sh_ua;
   logic [7:0]    r_sh_c0;
   logic [7:0]    r_sh_c1;
   logic          r_commit;
   logic          w_low;
   logic          w_capture;

   assign w_low     = (r_cnt != c_gap);
   assign w_capture = r_cur_on && (r_cur_cnt == c_last_low);

   // r_slot/r_cnt name the position shown next cycle; r_cur_* the one on the bus now
   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_slot     <= c_slot_ua0;
         r_cnt      <= '0;
         r_cur_slot <= c_slot_ua0;
         r_cur_cnt  <= '0;
         r_cur_on   <= 1'b0;
         nfpua0     <= 1'b1;
         nfpuc0     <= 1'b1;
         nfpuc1     <= 1'b1;
         nfpuc2     <= 1'b1;
         r_sh_ua    <= 8'h00;
         r_sh_c0    <= 8'h00;
         r_sh_c1    <= 8'h00;
         ua_low     <= 8'h00;
         ucontrol   <= 24'h000000;
         r_commit   <= 1'b0;
         snap_valid <= 1'b0;
      end else begin
         nfpua0     <= !(w_low && (r_slot == c_slot_ua0));
         nfpuc0     <= !(w_low && (r_slot == c_slot_uc0));
         nfpuc1     <= !(w_low && (r_slot == c_slot_uc1));
         nfpuc2     <= !(w_low && (r_slot == c_slot_uc2));
         r_cur_slot <= r_slot;
         r_cur_cnt  <= r_cnt;
         r_cur_on   <= 1'b1;
         if (r_cnt == c_gap) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 2'd1;
         end else begin
            r_cnt  <= r_cnt + CW'(1);
         end

         r_commit <= 1'b0;
         if (w_capture) begin
            case (r_cur_slot)
               c_slot_ua0: r_sh_ua <= fpd;
               c_slot_uc0: r_sh_c0 <= fpd;
               c_slot_uc1: r_sh_c1 <= fpd;
               default: begin
                  ua_low   <= r_sh_ua;
                  ucontrol <= {fpd, r_sh_c1, r_sh_c0};
                  r_commit <= 1'b1;
               end
            endcase
         end
         snap_valid <= r_commit;
      end
   end

   // ------------------------------------------------------------------------
   // Halt / step controller
   // ------------------------------------------------------------------------
   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [7:0] r_tcnt;
   logic       r_fetch;
   logic       w_accept;
   logic       w_expire;
   logic       w_load;
   logic       w_stepping;

   assign w_stepping = (r_state == c_step_exec) || (r_state == c_step_fetch);

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_expire = 1'b0;
      w_load   = 1'b0;
      case (r_state)
         c_run: begin
            if (cmd_stop) begin
               w_next   = c_halted;
               w_accept = 1'b1;
            end
         end
         c_halted: begin
            // stop outranks everything and has nothing to do while halted
            if (!cmd_stop) begin
               if (cmd_step) begin
                  w_next   = c_step_exec;
                  w_accept = 1'b1;
                  w_load   = 1'b1;
               end else if (cmd_ustep) begin
                  w_next   = c_ustep;
                  w_accept = 1'b1;
               end else if (cmd_run) begin
                  w_next   = c_run;
                  w_accept = 1'b1;
               end
            end
         end
         c_ustep: begin
            w_next = c_halted;
         end
         c_step_exec, c_step_fetch: begin
            if (cmd_stop) begin
               w_next   = c_halted;
               w_accept = 1'b1;
            end else if ((r_state == c_step_fetch) && r_fetch) begin
               w_next   = c_halted;
            end else if (r_tcnt == 8'd1) begin
               w_next   = c_halted;
               w_expire = 1'b1;
            end else if ((r_state == c_step_exec) && !r_fetch) begin
               w_next   = c_step_fetch;
            end
         end
         default: begin
            w_next = c_halted;
         end
      endcase
   end

   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_state      <= HALT_ON_RESET ? c_halted : c_run;
         halted       <= HALT_ON_RESET;
         r_tcnt       <= 8'h00;
         r_fetch      <= 1'b0;
         step_timeout <= 1'b0;
      end else begin
         r_fetch <= fpfetch;
         r_state <= w_next;
         halted  <= (w_next == c_halted);
         if (w_load) begin
            r_tcnt <= c_tmo_load;
         end else if (w_stepping) begin
            r_tcnt <= r_tcnt - 8'd1;
         end
         if (w_accept) begin
            step_timeout <= 1'b0;
         end else if (w_expire) begin
            step_timeout <= 1'b1;
         end
      end
   end

   assign nhalt = halted ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_dfp_ustate_scanner.sv
`default_nettype none
// ============================================================================
// tb_dfp_ustate_scanner : scoreboard bench for the front-panel scanner
// Rev 1.0
// ============================================================================
module tb_dfp_ustate_scanner;

   localparam int SETTLE       = 2;
   localparam int STEP_TIMEOUT = 255;
   localparam int FRAME        = 4 * (SETTLE + 1);

   logic        clk4      = 1'b0;
   logic        nreset    = 1'b0;
   logic [7:0]  fpd       = 8'h00;
   logic        nfpua0, nfpuc0, nfpuc1, nfpuc2;
   logic        fpfetch   = 1'b1;
   wire         nhalt;
   logic        cmd_run   = 1'b0;
   logic        cmd_stop  = 1'b0;
   logic        cmd_ustep = 1'b0;
   logic        cmd_step  = 1'b0;
   logic [7:0]  ua_low;
   logic [23:0] ucontrol;
   logic        snap_valid, halted, step_timeout;

   pullup (nhalt);

   dfp_ustate_scanner #(
      .SETTLE        (SETTLE),
      .STEP_TIMEOUT  (STEP_TIMEOUT),
      .HALT_ON_RESET (1'b0)
   ) dut (
      .clk4         (clk4),
      .nreset       (nreset),
      .fpd          (fpd),
      .nfpua0       (nfpua0),
      .nfpuc0       (nfpuc0),
      .nfpuc1       (nfpuc1),
      .nfpuc2       (nfpuc2),
      .fpfetch      (fpfetch),
      .nhalt        (nhalt),
      .cmd_run      (cmd_run),
      .cmd_stop     (cmd_stop),
      .cmd_ustep    (cmd_ustep),
      .cmd_step     (cmd_step),
      .ua_low       (ua_low),
      .ucontrol     (ucontrol),
      .snap_valid   (snap_valid),
      .halted       (halted),
      .step_timeout (step_timeout)
   );

   always #5 clk4 = ~clk4;

   int cyc = 0;
   always @(posedge clk4) cyc <= cyc + 1;

   int          checks   = 0;
   int          errors   = 0;
   bit          tracking = 1'b0;
   int          frame0   = 0;
   logic [31:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sequencer model: new random uState per frame; a buffer only shows its
   // real byte once it has been enabled for SETTLE cycles.
   logic [7:0]  cur_ua   = 8'h00;
   logic [23:0] cur_uc   = 24'h000000;
   int          lowcnt   = 0;
   int          prev_sel = -1;
   always @(posedge clk4) begin
      int         sel;
      logic [7:0] b;
      #1;
      if (!nreset) sb.delete();
      if (tracking && cyc >= frame0 && ((cyc - frame0) % FRAME) == 0) begin
         cur_ua = 8'($urandom);
         cur_uc = 24'($urandom);
         sb.push_back({cur_uc, cur_ua});
      end
      sel = !nfpua0 ? 0 : !nfpuc0 ? 1 : !nfpuc1 ? 2 : !nfpuc2 ? 3 : -1;
      if (sel < 0)              lowcnt = 0;
      else if (sel == prev_sel) lowcnt = lowcnt + 1;
      else                      lowcnt = 1;
      prev_sel = sel;
      case (sel)
         0:       b = cur_ua;
         1:       b = cur_uc[7:0];
         2:       b = cur_uc[15:8];
         default: b = cur_uc[23:16];
      endcase
      if (sel >= 0) fpd = (lowcnt == SETTLE) ? b : ~b;
      else          fpd = 8'($urandom);
   end

   // Monitor: enable pattern and snapshot scoreboard
   always @(negedge clk4) begin
      int          p;
      logic [3:0]  exp_n;
      logic [31:0] e;
      if (tracking && nreset && cyc >= frame0) begin
         p     = cyc - frame0;
         exp_n = 4'hF;
         if ((p % (SETTLE + 1)) < SETTLE) exp_n[(p % FRAME) / (SETTLE + 1)] = 1'b0;
         chk("enables", 32'({nfpuc2, nfpuc1, nfpuc0, nfpua0}), 32'(exp_n));
         chk("snap_valid", 32'(snap_valid), 32'((p >= FRAME) && ((p % FRAME) == 0)));
         if (snap_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL snapshot: snap_valid=1, expected no snapshot (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("ua_low", 32'(ua_low), 32'(e[7:0]));
               chk("ucontrol", 32'(ucontrol), 32'(e[31:8]));
            end
         end
      end
   end

   task automatic pulse(input logic run, input logic stop, input logic ustep, input logic step);
      cmd_run   = run;
      cmd_stop  = stop;
      cmd_ustep = ustep;
      cmd_step  = step;
      @(negedge clk4);
      cmd_run   = 1'b0;
      cmd_stop  = 1'b0;
      cmd_ustep = 1'b0;
      cmd_step  = 1'b0;
   endtask

   task automatic expect_halt(input string name, input logic h, input logic tmo);
      chk({name, "_halted"}, 32'(halted), 32'(h));
      chk({name, "_nhalt"}, 32'(nhalt), 32'(!h));
      chk({name, "_step_timeout"}, 32'(step_timeout), 32'(tmo));
   endtask

   initial begin
      int  busy;
      bit  found;

      repeat (3) @(negedge clk4);
      chk("rst_enables", 32'({nfpuc2, nfpuc1, nfpuc0, nfpua0}), 32'hF);
      chk("rst_ua_low", 32'(ua_low), 32'h0);
      chk("rst_ucontrol", 32'(ucontrol), 32'h0);
      chk("rst_snap_valid", 32'(snap_valid), 32'h0);
      expect_halt("rst", 1'b0, 1'b0);
      nreset   = 1'b1;
      frame0   = cyc + 1;
      tracking = 1'b1;
      repeat (3 * FRAME) @(negedge clk4);

      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      expect_halt("stop", 1'b1, 1'b0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      expect_halt("halted_run_stop", 1'b1, 1'b0);

      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      expect_halt("ustep_rel", 1'b0, 1'b0);
      @(negedge clk4);
      expect_halt("ustep_back", 1'b1, 1'b0);

      // instruction step with a normal fetch boundary
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_halt("step_go", 1'b0, 1'b0);
      repeat (2) @(negedge clk4);
      fpfetch = 1'b0;
      repeat (8) @(negedge clk4);
      expect_halt("step_mid", 1'b0, 1'b0);
      fpfetch = 1'b1;
      @(negedge clk4);
      expect_halt("step_reg_rise", 1'b0, 1'b0);
      @(negedge clk4);
      expect_halt("step_done", 1'b1, 1'b0);

      // instruction step that never reaches a fetch
      fpfetch = 1'b0;
      @(negedge clk4);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      busy = 0;
      for (int i = 1; i < STEP_TIMEOUT; i++) begin
         if (halted) busy++;
         @(negedge clk4);
      end
      chk("tmo_halted_early", 32'(busy), 32'd0);
      expect_halt("tmo_last_run", 1'b0, 1'b0);
      @(negedge clk4);
      expect_halt("tmo_hit", 1'b1, 1'b1);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      expect_halt("tmo_cleared", 1'b0, 1'b0);

      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      expect_halt("run_ignores_ustep", 1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      expect_halt("run_stop_prio", 1'b1, 1'b0);

      fpfetch = 1'b1;
      @(negedge clk4);
      pulse(1'b0, 1'b0, 1'b1, 1'b1);
      expect_halt("step_ustep_prio1", 1'b0, 1'b0);
      @(negedge clk4);
      expect_halt("step_ustep_prio2", 1'b0, 1'b0);
      fpfetch = 1'b0;
      repeat (3) @(negedge clk4);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      expect_halt("stop_in_fetch", 1'b1, 1'b0);

      // asynchronous reset in the middle of a frame
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         @(negedge clk4);
         if (((cyc - frame0) % FRAME) == 7 && (cyc - frame0) >= FRAME) found = 1'b1;
      end
      chk("midframe_align", 32'(found), 32'd1);
      #2;
      tracking = 1'b0;
      nreset   = 1'b0;
      #1;
      chk("arst_enables", 32'({nfpuc2, nfpuc1, nfpuc0, nfpua0}), 32'hF);
      chk("arst_ua_low", 32'(ua_low), 32'h0);
      chk("arst_ucontrol", 32'(ucontrol), 32'h0);
      chk("arst_snap_valid", 32'(snap_valid), 32'h0);
      expect_halt("arst", 1'b0, 1'b0);
      repeat (3) @(negedge clk4);
      nreset   = 1'b1;
      frame0   = cyc + 1;
      tracking = 1'b1;
      repeat (3 * FRAME + 2) @(negedge clk4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
